n64_joybus_rx: RTL

N64_JOYBUS_RX -- requirements
Module: n64_joybus_rx

---
 rtl/n64_pkg.sv | 32 +++
 rtl/n64_joybus_rx_if.sv | 28 ++
 rtl/joybus_sync.sv | 33 +++
 rtl/n64_joybus_rx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/n64_pkg.sv
// Shared constants and types for the joybus receiver.
//   BIT_US/SAMPLE_US : bit period and sample point in microseconds
//   err_t            : frame error codes reported on err_code
//   INFO..RESET      : joybus command byte values
//   state_t          : receiver FSM states
package n64_pkg;

  localparam int unsigned BIT_US    = 4;
  localparam int unsigned SAMPLE_US = 2;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_OVERFLOW = 2'b01,
    ERR_FRAME    = 2'b10,
    ERR_STUCK    = 2'b11
  } err_t;

  localparam logic [7:0] INFO  = 8'h00;
  localparam logic [7:0] POLL  = 8'h01;
  localparam logic [7:0] READ  = 8'h02;
  localparam logic [7:0] WRITE = 8'h03;
  localparam logic [7:0] RESET = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    CHECK,
    DRAIN
  } state_t;

endpackage

// File: rtl/n64_joybus_rx_if.sv
// Result and buffer-read bundle of the joybus receiver.
//   busy, frame_valid, frame_err, err_code, cmd, byte_cnt : frame status
//   rd_addr / rd_data : combinational read port into the frame buffer
// master = receiver side, slave = consumer side.
interface n64_joybus_rx_if #(
  parameter int unsigned MAX_BYTES = 35
);

  logic                             busy;
  logic                             frame_valid;
  logic                             frame_err;
  logic [1:0]                       err_code;
  logic [7:0]                       cmd;
  logic [$clog2(MAX_BYTES+1)-1:0]   byte_cnt;
  logic [$clog2(MAX_BYTES)-1:0]     rd_addr;
  logic [7:0]                       rd_data;

  modport master (
    output busy, frame_valid, frame_err, err_code, cmd, byte_cnt, rd_data,
    input  rd_addr
  );

  modport slave (
    input  busy, frame_valid, frame_err, err_code, cmd, byte_cnt, rd_data,
    output rd_addr
  );

endinterface

// File: rtl/joybus_sync.sv
// Two-flop synchronizer for the joybus line plus edge pulses.
//   sample_clk, reset_n : clock, async active-low reset (flops reset high = idle)
//   data                : asynchronous line
//   line                : synchronized line
//   fall_c / rise_c     : high during the first cycle line is low / high
module joybus_sync (
  input  logic sample_clk,
  input  logic reset_n,
  input  logic data,
  output logic line,
  output logic fall_c,
  output logic rise_c
);

  logic meta;
  logic line_d;

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= 1'b1;
      line   <= 1'b1;
      line_d <= 1'b1;
    end else begin
      meta   <= data;
      line   <= meta;
      line_d <= line;
    end
  end

  assign fall_c = line_d & ~line;
  assign rise_c = ~line_d & line;

endmodule

// File: rtl/n64_joybus_rx.sv
// N64 joybus frame receiver: decodes pulse-width bits MSB-first into a byte
// buffer and reports each frame as valid or with an error code.
//   sample_clk, reset_n : clock, async active-low reset
//   data                : asynchronous joybus line (idle high)
//   enable              : permits a new frame to start
//   bus                 : status outputs and buffer read port
module n64_joybus_rx
  import n64_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = 8,
  parameter int unsigned MAX_BYTES   = 35,
  parameter int unsigned IDLE_US     = 6
) (
  input  logic              sample_clk,
  input  logic              reset_n,
  input  logic              data,
  input  logic              enable,
  n64_joybus_rx_if.master   bus
);

  localparam int unsigned SAMPLE_CYC = SAMPLE_US * CLKS_PER_US;
  localparam int unsigned STUCK_CYC  = BIT_US * CLKS_PER_US;
  localparam int unsigned IDLE_CYC   = IDLE_US * CLKS_PER_US;
  localparam int unsigned CW = $clog2(STUCK_CYC + 1);
  localparam int unsigned HW = $clog2(IDLE_CYC + 1);
  localparam int unsigned BW = $clog2(MAX_BYTES + 1);
  localparam int unsigned AW = $clog2(MAX_BYTES);

  logic line_s, fall_c, rise_c;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [HW-1:0]  hi_cnt;
  logic [BW-1:0]  byte_idx, byte_idx_n;
  logic [2:0]     bit_pos, bit_pos_n;
  logic [6:0]     shreg, shreg_n;
  err_t           err_lat, err_lat_n, err_code_q, err_code_n;
  logic           busy_q, fv_q, fv_n, fe_q, fe_n;
  logic [7:0]     cmd_q, cmd_n;
  logic [BW-1:0]  byte_cnt_q, byte_cnt_n;
  logic [7:0]     mem [MAX_BYTES];

  logic           wr_en_c, sample_c, full_c, frame_ok_c;
  logic [7:0]     shift_c;
  logic [AW-1:0]  wr_addr_c;

  joybus_sync u_sync (
    .sample_clk (sample_clk),
    .reset_n    (reset_n),
    .data       (data),
    .line       (line_s),
    .fall_c     (fall_c),
    .rise_c     (rise_c)
  );

  // Consecutive cycles the synchronized line has been high (saturating).
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n)                      hi_cnt <= '0;
    else if (!line_s)                  hi_cnt <= '0;
    else if (hi_cnt != HW'(IDLE_CYC))  hi_cnt <= hi_cnt + HW'(1);
  end

  assign shift_c    = {shreg, line_s};
  assign sample_c   = ((state == LOW) || (state == HIGH)) && (cnt == CW'(SAMPLE_CYC));
  // Buffer already holds MAX_BYTES bytes plus a stop bit: any further bit overflows.
  assign full_c     = (byte_idx == BW'(MAX_BYTES)) && (bit_pos == 3'd1);
  assign frame_ok_c = (bit_pos == 3'd1) && (byte_idx != '0) && shreg[0];
  assign wr_addr_c  = AW'(byte_idx);

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    cnt_n      = (cnt != CW'(STUCK_CYC)) ? cnt + CW'(1) : cnt;
    byte_idx_n = byte_idx;
    bit_pos_n  = bit_pos;
    shreg_n    = shreg;
    err_lat_n  = err_lat;
    err_code_n = err_code_q;
    cmd_n      = cmd_q;
    byte_cnt_n = byte_cnt_q;
    fv_n       = 1'b0;
    fe_n       = 1'b0;
    wr_en_c    = 1'b0;

    case (state)
      IDLE: begin
        if (fall_c && enable) begin
          state_n    = LOW;
          cnt_n      = CW'(1);
          byte_idx_n = '0;
          bit_pos_n  = '0;
          err_lat_n  = ERR_NONE;
        end
      end
      LOW, HIGH: begin
        if (sample_c && full_c) begin
          state_n   = DRAIN;
          err_lat_n = ERR_OVERFLOW;
        end else begin
          if (sample_c) begin
            shreg_n = shift_c[6:0];
            if (bit_pos == 3'd7) begin
              wr_en_c    = 1'b1;
              byte_idx_n = byte_idx + BW'(1);
              bit_pos_n  = '0;
            end else begin
              bit_pos_n  = bit_pos + 3'd1;
            end
          end
          if (state == LOW) begin
            if (rise_c) begin
              state_n = HIGH;
            end else if (cnt == CW'(STUCK_CYC)) begin
              state_n   = DRAIN;
              err_lat_n = ERR_STUCK;
            end
          end else begin
            if (fall_c) begin
              state_n = LOW;
              cnt_n   = CW'(1);
            end else if (line_s && (hi_cnt == HW'(IDLE_CYC - 2))) begin
              // Pulse lands on the IDLE_CYC-th high cycle, same as DRAIN exit.
              state_n = CHECK;
            end
          end
        end
      end
      CHECK: begin
        state_n = IDLE;
        if (frame_ok_c) begin
          fv_n       = 1'b1;
          cmd_n      = mem[0];
          byte_cnt_n = byte_idx;
          err_code_n = ERR_NONE;
        end else begin
          fe_n       = 1'b1;
          err_code_n = ERR_FRAME;
        end
      end
      DRAIN: begin
        if (line_s && (hi_cnt == HW'(IDLE_CYC - 1))) begin
          state_n    = IDLE;
          fe_n       = 1'b1;
          err_code_n = err_lat;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      byte_idx   <= '0;
      bit_pos    <= '0;
      shreg      <= '0;
      err_lat    <= ERR_NONE;
      err_code_q <= ERR_NONE;
      cmd_q      <= 8'h00;
      byte_cnt_q <= '0;
      busy_q     <= 1'b0;
      fv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      byte_idx   <= byte_idx_n;
      bit_pos    <= bit_pos_n;
      shreg      <= shreg_n;
      err_lat    <= err_lat_n;
      err_code_q <= err_code_n;
      cmd_q      <= cmd_n;
      byte_cnt_q <= byte_cnt_n;
      busy_q     <= (state_n != IDLE);
      fv_q       <= fv_n;
      fe_q       <= fe_n;
    end
  end

  // Frame buffer; contents survive reset.
  always_ff @(posedge sample_clk) begin
    if (wr_en_c) mem[wr_addr_c] <= shift_c;
  end

  assign bus.rd_data     = ({1'b0, bus.rd_addr} < (AW+1)'(MAX_BYTES)) ? mem[bus.rd_addr] : 8'h00;
  assign bus.busy        = busy_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_err   = fe_q;
  assign bus.err_code    = err_code_q;
  assign bus.cmd         = cmd_q;
  assign bus.byte_cnt    = byte_cnt_q;

endmodule
